cpu_commit_tracer: RTL and testbench
====================================

Name: cpu_commit_tracer

Overview:
Passive observer that sits directly downstream of riscv_cpu and consumes its commit and monitor taps. It timestamps each retiring register write into a trace FIFO, which drains over a valid/ready stream to a logger or checker. It also maintains saturating event counters for commits, stalls, taken branches and forwarding. It never back-pressures the CPU; it drops records when full and counts the drops.

Parameters:
DEPTH, 16, trace FIFO entries (power of two, >= 2)
CNT_W, 32, width of every event counter
TS_W, 32, width of the free-running cycle timestamp
FILTER_X0, 1, when 1, commits with rd==0 are not recorded (still counted)

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
en  in  1  capture/count enable; when 0, no pushes and no counting except cycle_cnt
clr  in  1  synchronous clear of all counters, timestamp, FIFO and overflow flag
commit_valid  in  1  CPU retired a writeback this cycle
commit_rd  in  5  destination register of the commit
commit_wdata  in  32  writeback data
mon_forwardA  in  2  EX operand-A forward select (0 = none)
mon_forwardB  in  2  EX operand-B forward select (0 = none)
mon_stall  in  1  load-use stall asserted
mon_branch_taken  in  1  branch/jump redirect this cycle
mon_pc  in  32  current PC, sampled into stall records only
trc_valid  out  1  trace record available
trc_ready  in  1  consumer accepts record
trc_rd  out  5  record rd
trc_wdata  out  32  record data
trc_ts  out  TS_W  cycle timestamp at capture
cycle_cnt, commit_cnt, stall_cnt, branch_cnt, fwd_cnt, drop_cnt  out  CNT_W each  event counters
overflow  out  1  sticky: at least one record dropped since reset/clr
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): all counters, ts, FIFO pointers and overflow go to 0; trc_valid=0; trc_* data=0.
- Clear: clr has the same effect as reset, applied at the next edge. It has priority over all same-cycle events, and a push in the clr cycle is discarded.
- Timestamp: ts increments every cycle regardless of en and wraps modulo 2^TS_W. cycle_cnt equals ts but saturates.
- Push condition: en && commit_valid && !(FILTER_X0 && commit_rd==0). The record {rd, wdata, ts-of-that-cycle} is written at the edge.
- Latency: a pushed record is visible on trc_* one cycle after the commit cycle. There is no combinational bypass, so an empty FIFO shows trc_valid=0 during the commit cycle.
- Pop: occurs when trc_valid && trc_ready. trc_* hold stable while trc_valid && !trc_ready.
- Full: a push with level==DEPTH and no same-cycle pop is dropped. The drop increments drop_cnt and sets overflow. A push with a same-cycle pop at full is accepted and the level stays DEPTH.
- Empty: a pop is impossible because trc_valid=0. A simultaneous push at empty gives level 1 next cycle.
- Pointers: wrap modulo DEPTH. Level is derived from the extra MSB pointer scheme.
- Counters (only when en): each counter saturates at all-ones and never wraps.
  - commit_cnt += commit_valid, including rd==0.
  - stall_cnt += mon_stall.
  - branch_cnt += mon_branch_taken.
  - fwd_cnt += (mon_forwardA!=0) + (mon_forwardB!=0), so it can add 2 per cycle; saturation applies to the sum.
- drop_cnt increments for drops only, never for filtered x0 commits.
- mon_pc is reserved for future stall records and is unused in this revision; the lint waiver is documented.
- No state machine beyond the FIFO. Reset mid-stream clears trc_valid immediately (asynchronous) and loses all records.

Decomposition:
- ddv_mon_pkg:
  - trace_rec_t packed struct {rd[4:0], wdata[31:0], ts[TS_W-1:0]}
  - FWD_NONE=2'b00 constant
  - sat_inc function (value, increment 0..2, width-safe)
- Sub-module trace_fifo: parameterised DEPTH and element type, push/pop/full/empty/level, asynchronous active-low reset, synchronous clr. cpu_commit_tracer instantiates it once and owns the counters and filter.

Test Plan:
- Reset then 3 commits (rd=1/2/3, wdata=0x11/0x22/0x33) at ts=10,11,12 with trc_ready=1 -> three records appear at cycles 11..13 in order with trc_ts 10,11,12; commit_cnt=3; drop_cnt=0.
- trc_ready=0 and 20 commits with DEPTH=16 -> fifo_level=16, drop_cnt=4, overflow=1; draining then yields exactly the first 16 records in order.
- At full, push and pop in the same cycle -> level stays 16, drop_cnt unchanged, and the new record is last out.
- Commit with rd=0, FILTER_X0=1 -> no record, commit_cnt+1; with FILTER_X0=0 -> record rd=0 emitted.
- Cycle with forwardA=2'b10, forwardB=2'b01, mon_stall=1, branch=1 -> fwd_cnt+2, stall_cnt+1, branch_cnt+1; with CNT_W=4 and fwd_cnt=14 the same stimulus gives fwd_cnt=15, not 0.
- Assert rst_n low asynchronously mid-drain with 5 entries queued -> trc_valid falls before the next edge, and all counters, level and overflow read 0 after release; en=0 suppresses pushes while cycle_cnt still advances.

Source files
------------

// File: rtl/ddv_mon_pkg.sv
// Shared types, constants and helpers for the CPU commit tracer.
package ddv_mon_pkg;

  localparam int unsigned RD_W     = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REC_TS_W = 32;

  localparam logic [1:0] FWD_NONE = 2'b00;

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [DATA_W-1:0]   wdata;
    logic [REC_TS_W-1:0] ts;
  } trace_rec_t;

  // Saturating add of a 0..2 increment to a counter of the given width (<= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [1:0]  inc,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max;
    max = (width >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << width) - 65'd1);
    sum = {1'b0, value} + {63'd0, inc};
    if (sum > max) begin
      sum = max;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/cpu_commit_tracer_if.sv
// Trace record valid/ready stream from the tracer to a logger or checker.
interface cpu_commit_tracer_if #(
  parameter int unsigned TS_W = 32
) ();

  logic            trc_valid;
  logic            trc_ready;
  logic [4:0]      trc_rd;
  logic [31:0]     trc_wdata;
  logic [TS_W-1:0] trc_ts;

  modport master (output trc_valid, trc_rd, trc_wdata, trc_ts, input trc_ready);
  modport slave  (input trc_valid, trc_rd, trc_wdata, trc_ts, output trc_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is zero while empty.
module trace_fifo
  import ddv_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = trace_rec_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A push at full is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (!empty) begin
      rdata = mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/cpu_commit_tracer.sv
// Passive commit tracer: timestamps retiring writes into a trace FIFO and
// keeps saturating event counters; never back-pressures the CPU.
module cpu_commit_tracer
  import ddv_mon_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TS_W      = 32,
  parameter bit          FILTER_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   commit_valid,
  input  logic [4:0]             commit_rd,
  input  logic [31:0]            commit_wdata,
  input  logic [1:0]             mon_forwardA,
  input  logic [1:0]             mon_forwardB,
  input  logic                   mon_stall,
  input  logic                   mon_branch_taken,
  input  logic [31:0]            mon_pc,
  cpu_commit_tracer_if.master    trc,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       commit_cnt,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       fwd_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  ts_nxt;
  logic [CNT_W-1:0] cycle_nxt;
  logic [CNT_W-1:0] commit_nxt;
  logic [CNT_W-1:0] stall_nxt;
  logic [CNT_W-1:0] branch_nxt;
  logic [CNT_W-1:0] fwd_nxt;
  logic [CNT_W-1:0] drop_nxt;
  logic             ovf_nxt;
  logic             push_req;
  logic             drop;
  logic             full;
  logic             empty;
  logic [1:0]       fwd_inc;
  trace_rec_t       wr_rec;
  trace_rec_t       rd_rec;

  // mon_pc is reserved for future stall records; folded into an unused sink.
  logic unused_pc;
  assign unused_pc = ^mon_pc;

  assign push_req = en && commit_valid && !(FILTER_X0 && (commit_rd == 5'd0));
  // Full implies non-empty, so the head pops exactly when the consumer is ready.
  assign drop     = push_req && full && !trc.trc_ready;
  assign fwd_inc  = 2'({1'b0, mon_forwardA != FWD_NONE} + {1'b0, mon_forwardB != FWD_NONE});

  assign wr_rec.rd    = commit_rd;
  assign wr_rec.wdata = commit_wdata;
  assign wr_rec.ts    = REC_TS_W'(ts);

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push_req),
    .pop   (trc.trc_ready),
    .wdata (wr_rec),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign trc.trc_valid = !empty;
  assign trc.trc_rd    = rd_rec.rd;
  assign trc.trc_wdata = rd_rec.wdata;
  assign trc.trc_ts    = TS_W'(rd_rec.ts);

  // Next-state for timestamp and counters; cycle_cnt ignores en.
  always_comb begin
    ts_nxt     = ts + TS_W'(1);
    cycle_nxt  = CNT_W'(sat_inc(64'(cycle_cnt), 2'd1, CNT_W));
    commit_nxt = commit_cnt;
    stall_nxt  = stall_cnt;
    branch_nxt = branch_cnt;
    fwd_nxt    = fwd_cnt;
    drop_nxt   = drop_cnt;
    ovf_nxt    = overflow;
    if (en) begin
      commit_nxt = CNT_W'(sat_inc(64'(commit_cnt), {1'b0, commit_valid}, CNT_W));
      stall_nxt  = CNT_W'(sat_inc(64'(stall_cnt), {1'b0, mon_stall}, CNT_W));
      branch_nxt = CNT_W'(sat_inc(64'(branch_cnt), {1'b0, mon_branch_taken}, CNT_W));
      fwd_nxt    = CNT_W'(sat_inc(64'(fwd_cnt), fwd_inc, CNT_W));
    end
    if (drop) begin
      drop_nxt = CNT_W'(sat_inc(64'(drop_cnt), 2'd1, CNT_W));
      ovf_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
      stall_cnt  <= '0;
      branch_cnt <= '0;
      fwd_cnt    <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      ts         <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
      stall_cnt  <= '0;
      branch_cnt <= '0;
      fwd_cnt    <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      ts         <= ts_nxt;
      cycle_cnt  <= cycle_nxt;
      commit_cnt <= commit_nxt;
      stall_cnt  <= stall_nxt;
      branch_cnt <= branch_nxt;
      fwd_cnt    <= fwd_nxt;
      drop_cnt   <= drop_nxt;
      overflow   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_commit_tracer.sv
// Randomized bench for cpu_commit_tracer against a queue-based reference model.
module tb_cpu_commit_tracer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1, clr = 1'b0, commit_valid = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_wdata = '0, pc = '0;
  logic [1:0]  fwd_a = '0, fwd_b = '0;
  logic        stall = 1'b0, branch = 1'b0, ready = 1'b0;

  logic [31:0] cyc0, com0, st0, br0, fw0, dr0;
  logic [3:0]  cyc1, com1, st1, br1, fw1, dr1;
  logic        ovf0, ovf1;
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  cpu_commit_tracer_if #(.TS_W(32)) if0 ();
  cpu_commit_tracer_if #(.TS_W(32)) if1 ();
  assign if0.trc_ready = ready;
  assign if1.trc_ready = ready;

  cpu_commit_tracer u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .mon_forwardA(fwd_a),
    .mon_forwardB(fwd_b), .mon_stall(stall), .mon_branch_taken(branch), .mon_pc(pc),
    .trc(if0), .cycle_cnt(cyc0), .commit_cnt(com0), .stall_cnt(st0),
    .branch_cnt(br0), .fwd_cnt(fw0), .drop_cnt(dr0), .overflow(ovf0), .fifo_level(lvl0)
  );

  cpu_commit_tracer #(.DEPTH(4), .CNT_W(4), .TS_W(32), .FILTER_X0(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .mon_forwardA(fwd_a),
    .mon_forwardB(fwd_b), .mon_stall(stall), .mon_branch_taken(branch), .mon_pc(pc),
    .trc(if1), .cycle_cnt(cyc1), .commit_cnt(com1), .stall_cnt(st1),
    .branch_cnt(br1), .fwd_cnt(fw1), .drop_cnt(dr1), .overflow(ovf1), .fifo_level(lvl1)
  );

  // Reference model: one record queue and counter set per instance.
  int     mdepth [2] = '{16, 4};
  longint mmax   [2] = '{64'hFFFF_FFFF, 15};
  bit     mfilt  [2] = '{1'b1, 1'b0};
  logic [68:0] mq0 [$];
  logic [68:0] mq1 [$];
  longint mts [2], mcyc [2], mcom [2], mst [2], mbr [2], mfw [2], mdr [2];
  bit     movf [2];

  function automatic longint sat(input longint v, input longint inc, input longint mx);
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  task automatic model_clear(input int m);
    if (m == 0) mq0.delete(); else mq1.delete();
    mts[m] = 0; mcyc[m] = 0; mcom[m] = 0; mst[m] = 0;
    mbr[m] = 0; mfw[m] = 0; mdr[m] = 0; movf[m] = 1'b0;
  endtask

  task automatic model_step(input int m);
    logic [68:0] q [$];
    bit popd, pushr;
    longint mx;
    mx = mmax[m];
    if (m == 0) q = mq0; else q = mq1;
    if (clr) begin
      model_clear(m);
      q.delete();
    end else begin
      popd  = (q.size() > 0) && ready;
      pushr = en && commit_valid && !(mfilt[m] && commit_rd == 5'd0);
      if (pushr && q.size() == mdepth[m] && !popd) begin
        mdr[m]  = sat(mdr[m], 1, mx);
        movf[m] = 1'b1;
        pushr   = 1'b0;
      end
      if (popd)  void'(q.pop_front());
      if (pushr) q.push_back({commit_rd, commit_wdata, 32'(mts[m])});
      mts[m]  = (mts[m] + 1) % 64'h1_0000_0000;
      mcyc[m] = sat(mcyc[m], 1, mx);
      if (en) begin
        mcom[m] = sat(mcom[m], longint'(commit_valid), mx);
        mst[m]  = sat(mst[m], longint'(stall), mx);
        mbr[m]  = sat(mbr[m], longint'(branch), mx);
        mfw[m]  = sat(mfw[m], longint'(fwd_a != 2'd0) + longint'(fwd_b != 2'd0), mx);
      end
    end
    if (m == 0) mq0 = q; else mq1 = q;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int m, input logic v, input logic [4:0] rd,
                            input logic [31:0] wd, input logic [31:0] ts,
                            input logic [4:0] lvl, input logic [31:0] cyc,
                            input logic [31:0] com, input logic [31:0] st,
                            input logic [31:0] br, input logic [31:0] fw,
                            input logic [31:0] dr, input logic ovf);
    logic [68:0] head;
    int sz;
    sz   = (m == 0) ? mq0.size() : mq1.size();
    head = '0;
    if (sz > 0) head = (m == 0) ? mq0[0] : mq1[0];
    chk($sformatf("u%0d.trc_valid", m), 64'(v), 64'(sz > 0));
    chk($sformatf("u%0d.trc_rd", m), 64'(rd), 64'(head[68:64]));
    chk($sformatf("u%0d.trc_wdata", m), 64'(wd), 64'(head[63:32]));
    chk($sformatf("u%0d.trc_ts", m), 64'(ts), 64'(head[31:0]));
    chk($sformatf("u%0d.fifo_level", m), 64'(lvl), 64'(sz));
    chk($sformatf("u%0d.cycle_cnt", m), 64'(cyc), mcyc[m]);
    chk($sformatf("u%0d.commit_cnt", m), 64'(com), mcom[m]);
    chk($sformatf("u%0d.stall_cnt", m), 64'(st), mst[m]);
    chk($sformatf("u%0d.branch_cnt", m), 64'(br), mbr[m]);
    chk($sformatf("u%0d.fwd_cnt", m), 64'(fw), mfw[m]);
    chk($sformatf("u%0d.drop_cnt", m), 64'(dr), mdr[m]);
    chk($sformatf("u%0d.overflow", m), 64'(ovf), 64'(movf[m]));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_inst(0, if0.trc_valid, if0.trc_rd, if0.trc_wdata, if0.trc_ts, lvl0,
                 cyc0, com0, st0, br0, fw0, dr0, ovf0);
      check_inst(1, if1.trc_valid, if1.trc_rd, if1.trc_wdata, if1.trc_ts, 5'(lvl1),
                 32'(cyc1), 32'(com1), 32'(st1), 32'(br1), 32'(fw1), 32'(dr1), ovf1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] wd);
    commit_valid = 1'b1;
    commit_rd    = rd;
    commit_wdata = wd;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 checking = 1'b1;
    tick(); tick();
    chk("rst.trc_valid", 64'(if0.trc_valid), 64'd0);
    chk("rst.level", 64'(lvl0), 64'd0);
    chk("rst.cycle_cnt", 64'(cyc0), 64'd0);
    chk("rst.trc_wdata", 64'(if0.trc_wdata), 64'd0);
    rst_n = 1'b1;

    // Three back-to-back commits at ts 10..12 with a ready consumer.
    repeat (10) tick();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      commit(5'(i + 1), 32'((i + 1) * 32'h11));
      tick();
      chk("p1.valid", 64'(if0.trc_valid), 64'd1);
      chk("p1.rd", 64'(if0.trc_rd), 64'(i + 1));
      chk("p1.wdata", 64'(if0.trc_wdata), 64'((i + 1) * 32'h11));
      chk("p1.ts", 64'(if0.trc_ts), 64'(10 + i));
    end
    commit_valid = 1'b0;
    tick();
    chk("p1.empty", 64'(if0.trc_valid), 64'd0);
    chk("p1.commit_cnt", 64'(com0), 64'd3);
    chk("p1.drop_cnt", 64'(dr0), 64'd0);

    // Overfill with the consumer stalled, then push+pop at full, then drain.
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit(5'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    chk("p2.level", 64'(lvl0), 64'd16);
    chk("p2.drop_cnt", 64'(dr0), 64'd4);
    chk("p2.overflow", 64'(ovf0), 64'd1);
    chk("p2.head", 64'(if0.trc_rd), 64'd1);
    commit(5'd31, 32'hABC);
    ready = 1'b1;
    tick();
    chk("p2.pp_level", 64'(lvl0), 64'd16);
    chk("p2.pp_drop", 64'(dr0), 64'd4);
    commit_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("p2.drain_rd", 64'(if0.trc_rd), (j < 15) ? 64'(j + 2) : 64'd31);
      chk("p2.drain_wd", 64'(if0.trc_wdata), (j < 15) ? 64'(32'h101 + 32'(j)) : 64'hABC);
      tick();
    end
    chk("p2.drained", 64'(if0.trc_valid), 64'd0);

    // Clear with a same-cycle commit, then an x0 commit.
    ready = 1'b0;
    clr   = 1'b1;
    commit(5'd5, 32'h55);
    tick();
    clr = 1'b0;
    chk("p3.clr_level", 64'(lvl0), 64'd0);
    chk("p3.clr_commit", 64'(com0), 64'd0);
    chk("p3.clr_ovf", 64'(ovf0), 64'd0);
    commit(5'd0, 32'hDEAD);
    tick();
    commit_valid = 1'b0;
    chk("p3.x0_commit_cnt", 64'(com0), 64'd1);
    chk("p3.x0_filtered", 64'(lvl0), 64'd0);
    chk("p3.x0_kept_valid", 64'(if1.trc_valid), 64'd1);
    chk("p3.x0_kept_rd", 64'(if1.trc_rd), 64'd0);
    chk("p3.x0_kept_wd", 64'(if1.trc_wdata), 64'hDEAD);

    // Monitor events; the 4-bit instance must saturate fwd_cnt at 15.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    fwd_a = 2'b10; fwd_b = 2'b01; stall = 1'b1; branch = 1'b1;
    tick();
    chk("p4.fwd", 64'(fw0), 64'd2);
    chk("p4.stall", 64'(st0), 64'd1);
    chk("p4.branch", 64'(br0), 64'd1);
    repeat (6) tick();
    chk("p4.fwd14", 64'(fw1), 64'd14);
    tick();
    chk("p4.fwd_sat", 64'(fw1), 64'd15);
    chk("p4.fwd16", 64'(fw0), 64'd16);
    chk("p4.stall8", 64'(st1), 64'd8);
    fwd_a = 2'b00; fwd_b = 2'b00; stall = 1'b0; branch = 1'b0;

    // Asynchronous reset while five records are queued.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      commit(5'(i + 1), 32'(i));
      tick();
    end
    commit_valid = 1'b0;
    ready = 1'b1;
    #3;
    chk("p5.queued", 64'(lvl0), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("p5.async_valid", 64'(if0.trc_valid), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("p5.level", 64'(lvl0), 64'd0);
    chk("p5.commit", 64'(com0), 64'd0);
    chk("p5.overflow", 64'(ovf0), 64'd0);
    en = 1'b0;
    commit(5'd7, 32'h77);
    repeat (5) tick();
    chk("p5.en0_level", 64'(lvl0), 64'd0);
    chk("p5.en0_commit", 64'(com0), 64'd0);
    chk("p5.en0_cycle", 64'(cyc0), 64'd5);
    en = 1'b1;
    commit_valid = 1'b0;

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 1500; k++) begin
      en           = ($urandom_range(0, 7) != 0);
      clr          = ($urandom_range(0, 96) == 0);
      commit_valid = ($urandom_range(0, 3) != 0);
      commit_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      commit_wdata = $urandom;
      pc           = $urandom;
      fwd_a        = 2'($urandom);
      fwd_b        = 2'($urandom);
      stall        = ($urandom_range(0, 3) == 0);
      branch       = ($urandom_range(0, 3) == 0);
      ready        = ($urandom_range(0, 9) < ((k < 750) ? 3 : 8));
      tick();
    end
    clr = 1'b0;
    commit_valid = 1'b0;
    ready = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
